// File: rtl/arp_pkg.sv
// Shared ARP constants, payload field offsets and cache entry layout.
package arp_pkg;

   // Header field values that an Ethernet/IPv4 ARP frame must carry
   localparam logic [15:0] ARP_HTYPE_ETH   = 16'h0001;
   localparam logic [15:0] ARP_PTYPE_IPV4  = 16'h0800;
   localparam logic [7:0]  ARP_HLEN        = 8'd6;
   localparam logic [7:0]  ARP_PLEN        = 8'd4;
   localparam logic [15:0] ARP_OPER_REQ    = 16'd1;
   localparam logic [15:0] ARP_OPER_REP    = 16'd2;
   localparam int          ARP_PAYLOAD_LEN = 28;

   // Byte offset of each field inside the ARP payload
   localparam int OFF_HTYPE = 0;
   localparam int OFF_PTYPE = 2;
   localparam int OFF_HLEN  = 4;
   localparam int OFF_PLEN  = 5;
   localparam int OFF_OPER  = 6;
   localparam int OFF_SHA   = 8;
   localparam int OFF_SPA   = 14;
   localparam int OFF_THA   = 18;
   localparam int OFF_TPA   = 24;

   // One IP->MAC binding held by the cache
   typedef struct packed {
      logic        valid;
      logic [31:0] ip;
      logic [47:0] mac;
   } arp_entry_t;

   // Parser states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RECV  = 2'd1,
      ST_CHECK = 2'd2
   } arp_state_e;

endpackage

// File: rtl/arp_cache.sv
// N-entry IP->MAC table: learn with in-place update / first-free / round-robin
// eviction, plus a registered single-cycle lookup port.
module arp_cache
   import arp_pkg::*;
#(
   parameter int P_CACHE_DEPTH = 4
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_wr_en,
   input  logic [31:0] i_wr_ip,
   input  logic [47:0] i_wr_mac,
   input  logic [31:0] i_lookup_ip,
   input  logic        i_lookup_valid,
   output logic [47:0] o_lookup_mac,
   output logic        o_lookup_hit,
   output logic        o_lookup_done
);

   localparam int IDX_W = (P_CACHE_DEPTH > 1) ? $clog2(P_CACHE_DEPTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(P_CACHE_DEPTH - 1);

   arp_entry_t       table_r [P_CACHE_DEPTH];
   logic [IDX_W-1:0] ptr_r;

   logic             match_found_s;
   logic [IDX_W-1:0] match_idx_s;
   logic             free_found_s;
   logic [IDX_W-1:0] free_idx_s;
   logic [IDX_W-1:0] wr_idx_s;
   logic             ptr_adv_s;
   logic             look_hit_s;
   logic [47:0]      look_mac_s;

   // Parallel compare: existing binding, lowest free slot, and lookup hit
   always_comb begin
      match_found_s = 1'b0;
      match_idx_s   = {IDX_W{1'b0}};
      free_found_s  = 1'b0;
      free_idx_s    = {IDX_W{1'b0}};
      look_hit_s    = 1'b0;
      look_mac_s    = 48'h0;
      // Descending scan so the lowest matching index is the one kept
      for (int i = P_CACHE_DEPTH - 1; i >= 0; i--) begin
         match_idx_s   = (table_r[i].valid && (table_r[i].ip == i_wr_ip)) ? IDX_W'(i) : match_idx_s;
         match_found_s = match_found_s | (table_r[i].valid && (table_r[i].ip == i_wr_ip));
         free_idx_s    = (!table_r[i].valid) ? IDX_W'(i) : free_idx_s;
         free_found_s  = free_found_s | !table_r[i].valid;
         look_mac_s    = (table_r[i].valid && (table_r[i].ip == i_lookup_ip)) ? table_r[i].mac : look_mac_s;
         look_hit_s    = look_hit_s | (table_r[i].valid && (table_r[i].ip == i_lookup_ip));
      end
      wr_idx_s  = match_found_s ? match_idx_s : (free_found_s ? free_idx_s : ptr_r);
      ptr_adv_s = i_wr_en && !match_found_s && !free_found_s;
   end

   // Table write, replacement pointer and lookup result registers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < P_CACHE_DEPTH; i++) begin
            table_r[i] <= {$bits(arp_entry_t){1'b0}};
         end
         ptr_r         <= {IDX_W{1'b0}};
         o_lookup_mac  <= 48'h0;
         o_lookup_hit  <= 1'b0;
         o_lookup_done <= 1'b0;
      end else begin
         if (i_wr_en) begin
            table_r[wr_idx_s] <= '{valid: 1'b1, ip: i_wr_ip, mac: i_wr_mac};
         end
         if (ptr_adv_s) begin
            ptr_r <= (ptr_r == LAST_IDX) ? {IDX_W{1'b0}} : ptr_r + IDX_W'(1);
         end
         o_lookup_done <= i_lookup_valid;
         o_lookup_hit  <= i_lookup_valid && look_hit_s;
         o_lookup_mac  <= (i_lookup_valid && look_hit_s) ? look_mac_s : 48'h0;
      end
   end

endmodule

// File: rtl/arp_rx_cache.sv
// ARP receive engine: byte-indexed payload parser, frame validation against the
// local IP, and learning into the attached ARP cache.
module arp_rx_cache
   import arp_pkg::*;
#(
   parameter logic [31:0] P_SOURCE_IP   = 32'hC0A80102,
   parameter logic [47:0] P_SOURCE_MAC  = 48'h000000000000,
   parameter int          P_CACHE_DEPTH = 4
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_source_ip,
   input  logic        i_s_ip_valid,
   input  logic [7:0]  i_mac_data,
   input  logic        i_mac_last,
   input  logic        i_mac_valid,
   input  logic [31:0] i_lookup_ip,
   input  logic        i_lookup_valid,
   output logic [47:0] o_lookup_mac,
   output logic        o_lookup_hit,
   output logic        o_lookup_done,
   output logic [47:0] o_target_mac,
   output logic [31:0] o_target_ip,
   output logic        o_target_valid,
   output logic        o_trig_reply,
   output logic        o_ip_conflict
);

   arp_state_e  state_r, state_s;
   logic [4:0]  cnt_r, cnt_s, idx_s;
   logic [31:0] local_ip_r;
   logic [15:0] htype_r, htype_s, ptype_r, ptype_s, oper_r, oper_s;
   logic [7:0]  hlen_r, hlen_s, plen_r, plen_s;
   logic [47:0] sha_r, sha_s;
   logic [31:0] spa_r, spa_s, tpa_r, tpa_s;
   logic        end_s, hdr_ok_s, accept_s, conflict_s;

   // Parser state register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next state; a byte seen in IDLE or CHECK opens a new frame
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE, ST_CHECK: begin
            if (i_mac_valid) begin
               state_s = i_mac_last ? ST_CHECK : ST_RECV;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RECV: begin
            if (i_mac_valid && i_mac_last) begin
               state_s = ST_CHECK;
            end else begin
               state_s = ST_RECV;
            end
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // Byte index / counter and field capture of the current beat; fields shift
   // in MSB first, so completed values are visible on the last beat itself
   always_comb begin
      idx_s   = (state_r == ST_RECV) ? cnt_r : 5'd0;
      cnt_s   = cnt_r;
      htype_s = htype_r;
      ptype_s = ptype_r;
      hlen_s  = hlen_r;
      plen_s  = plen_r;
      oper_s  = oper_r;
      sha_s   = sha_r;
      spa_s   = spa_r;
      tpa_s   = tpa_r;
      if (i_mac_valid) begin
         cnt_s = (idx_s < 5'(ARP_PAYLOAD_LEN)) ? idx_s + 5'd1 : idx_s;
         case (idx_s) inside
            [5'(OFF_HTYPE):5'(OFF_PTYPE - 1)]:       htype_s = {htype_r[7:0], i_mac_data};
            [5'(OFF_PTYPE):5'(OFF_HLEN - 1)]:        ptype_s = {ptype_r[7:0], i_mac_data};
            5'(OFF_HLEN):                            hlen_s  = i_mac_data;
            5'(OFF_PLEN):                            plen_s  = i_mac_data;
            [5'(OFF_OPER):5'(OFF_SHA - 1)]:          oper_s  = {oper_r[7:0], i_mac_data};
            [5'(OFF_SHA):5'(OFF_SPA - 1)]:           sha_s   = {sha_r[39:0], i_mac_data};
            [5'(OFF_SPA):5'(OFF_THA - 1)]:           spa_s   = {spa_r[23:0], i_mac_data};
            [5'(OFF_THA):5'(OFF_TPA - 1)]:           ;  // target MAC is not needed
            [5'(OFF_TPA):5'(ARP_PAYLOAD_LEN - 1)]:   tpa_s   = {tpa_r[23:0], i_mac_data};
            default:                                 ;  // padding
         endcase
      end else begin
         cnt_s = cnt_r;
      end
   end

   // Accept / conflict decision evaluated on the last beat of a frame
   always_comb begin
      end_s    = i_mac_valid && i_mac_last;
      hdr_ok_s = (cnt_s == 5'(ARP_PAYLOAD_LEN)) &&
                 (htype_s == ARP_HTYPE_ETH) && (ptype_s == ARP_PTYPE_IPV4) &&
                 (hlen_s == ARP_HLEN) && (plen_s == ARP_PLEN) &&
                 ((oper_s == ARP_OPER_REQ) || (oper_s == ARP_OPER_REP)) &&
                 (tpa_s == local_ip_r) && (sha_s != P_SOURCE_MAC);
      conflict_s = end_s && hdr_ok_s && (spa_s == local_ip_r);
      accept_s   = end_s && hdr_ok_s && (spa_s != local_ip_r);
   end

   // Datapath registers: counter, captured fields, local IP and result outputs
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt_r          <= 5'd0;
         htype_r        <= 16'h0;
         ptype_r        <= 16'h0;
         hlen_r         <= 8'h0;
         plen_r         <= 8'h0;
         oper_r         <= 16'h0;
         sha_r          <= 48'h0;
         spa_r          <= 32'h0;
         tpa_r          <= 32'h0;
         local_ip_r     <= P_SOURCE_IP;
         o_target_mac   <= 48'h0;
         o_target_ip    <= 32'h0;
         o_target_valid <= 1'b0;
         o_trig_reply   <= 1'b0;
         o_ip_conflict  <= 1'b0;
      end else begin
         cnt_r   <= cnt_s;
         htype_r <= htype_s;
         ptype_r <= ptype_s;
         hlen_r  <= hlen_s;
         plen_r  <= plen_s;
         oper_r  <= oper_s;
         sha_r   <= sha_s;
         spa_r   <= spa_s;
         tpa_r   <= tpa_s;
         if (i_s_ip_valid) begin
            local_ip_r <= i_source_ip;
         end
         if (accept_s) begin
            o_target_mac <= sha_s;
            o_target_ip  <= spa_s;
         end
         o_target_valid <= accept_s;
         o_trig_reply   <= accept_s && (oper_s == ARP_OPER_REQ);
         o_ip_conflict  <= conflict_s;
      end
   end

   arp_cache #(
      .P_CACHE_DEPTH (P_CACHE_DEPTH)
   ) u_cache (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_wr_en        (accept_s),
      .i_wr_ip        (spa_s),
      .i_wr_mac       (sha_s),
      .i_lookup_ip    (i_lookup_ip),
      .i_lookup_valid (i_lookup_valid),
      .o_lookup_mac   (o_lookup_mac),
      .o_lookup_hit   (o_lookup_hit),
      .o_lookup_done  (o_lookup_done)
   );

endmodule

// File: tb/tb_arp_rx_cache.sv
// Directed bench for arp_rx_cache with hand-computed expectations.
module tb_arp_rx_cache;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic [31:0] i_source_ip;
   logic        i_s_ip_valid;
   logic [7:0]  i_mac_data;
   logic        i_mac_last;
   logic        i_mac_valid;
   logic [31:0] i_lookup_ip;
   logic        i_lookup_valid;
   logic [47:0] o_lookup_mac;
   logic        o_lookup_hit;
   logic        o_lookup_done;
   logic [47:0] o_target_mac;
   logic [31:0] o_target_ip;
   logic        o_target_valid;
   logic        o_trig_reply;
   logic        o_ip_conflict;

   int n_checks = 0;
   int n_pass   = 0;

   localparam logic [31:0] IP_LOCAL = 32'hC0A80102;

   always #5 i_clk = ~i_clk;

   arp_rx_cache dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_source_ip    (i_source_ip),
      .i_s_ip_valid   (i_s_ip_valid),
      .i_mac_data     (i_mac_data),
      .i_mac_last     (i_mac_last),
      .i_mac_valid    (i_mac_valid),
      .i_lookup_ip    (i_lookup_ip),
      .i_lookup_valid (i_lookup_valid),
      .o_lookup_mac   (o_lookup_mac),
      .o_lookup_hit   (o_lookup_hit),
      .o_lookup_done  (o_lookup_done),
      .o_target_mac   (o_target_mac),
      .o_target_ip    (o_target_ip),
      .o_target_valid (o_target_valid),
      .o_trig_reply   (o_trig_reply),
      .o_ip_conflict  (o_ip_conflict)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one ARP payload; returns #1 after the edge that sampled the last byte
   task automatic send_frame(input logic [15:0] oper, input logic [47:0] sha,
                             input logic [31:0] spa, input logic [31:0] tpa,
                             input logic [15:0] ptype, input int nbytes, input bit gaps);
      logic [7:0] b [64];
      for (int k = 0; k < 64; k++) b[k] = 8'h00;
      b[0] = 8'h00; b[1] = 8'h01;
      b[2] = ptype[15:8]; b[3] = ptype[7:0];
      b[4] = 8'd6; b[5] = 8'd4;
      b[6] = oper[15:8]; b[7] = oper[7:0];
      for (int j = 0; j < 6; j++) b[8 + j]  = sha[47 - 8*j -: 8];
      for (int j = 0; j < 4; j++) b[14 + j] = spa[31 - 8*j -: 8];
      for (int j = 0; j < 4; j++) b[24 + j] = tpa[31 - 8*j -: 8];
      for (int k = 0; k < nbytes; k++) begin
         if (gaps && (k % 5 == 2)) begin
            i_mac_valid = 1'b0;
            @(posedge i_clk); #1;
         end
         i_mac_data  = b[k];
         i_mac_valid = 1'b1;
         i_mac_last  = (k == nbytes - 1);
         @(posedge i_clk); #1;
      end
      i_mac_valid = 1'b0;
      i_mac_last  = 1'b0;
   endtask

   task automatic send_req(input logic [47:0] sha, input logic [31:0] spa, input logic [31:0] tpa);
      send_frame(16'd1, sha, spa, tpa, 16'h0800, 28, 1'b0);
   endtask

   task automatic check_pulses(input string tag, input logic tv, input logic trig, input logic conf);
      check({tag, "_tv"},   o_target_valid, tv);
      check({tag, "_trig"}, o_trig_reply,   trig);
      check({tag, "_conf"}, o_ip_conflict,  conf);
   endtask

   task automatic lookup(input string tag, input logic [31:0] ip, input logic hit, input logic [47:0] mac);
      i_lookup_ip    = ip;
      i_lookup_valid = 1'b1;
      @(posedge i_clk); #1;
      i_lookup_valid = 1'b0;
      check({tag, "_done"}, o_lookup_done, 1'b1);
      check({tag, "_hit"},  o_lookup_hit,  hit);
      check({tag, "_mac"},  o_lookup_mac,  mac);
   endtask

   task automatic pulse_reset();
      i_rst = 1'b1;
      @(posedge i_clk); #1;
      i_rst = 1'b0;
   endtask

   // Bound on total run time
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      i_rst = 1'b1; i_source_ip = 32'h0; i_s_ip_valid = 1'b0;
      i_mac_data = 8'h00; i_mac_last = 1'b0; i_mac_valid = 1'b0;
      i_lookup_ip = 32'h0; i_lookup_valid = 1'b0;
      repeat (3) @(posedge i_clk);
      #1;
      check_pulses("rst", 1'b0, 1'b0, 1'b0);
      check("rst_tmac", o_target_mac, 48'h0);
      check("rst_tip", o_target_ip, 32'h0);
      check("rst_ldone", o_lookup_done, 1'b0);
      i_rst = 1'b0;
      @(posedge i_clk); #1;

      // Request to us, padded to 46 bytes
      send_frame(16'd1, 48'h001122334455, 32'hC0A80101, IP_LOCAL, 16'h0800, 46, 1'b0);
      check_pulses("req", 1'b1, 1'b1, 1'b0);
      check("req_tmac", o_target_mac, 48'h001122334455);
      check("req_tip", o_target_ip, 32'hC0A80101);
      @(posedge i_clk); #1;
      check_pulses("req_next", 1'b0, 1'b0, 1'b0);
      check("req_hold_tip", o_target_ip, 32'hC0A80101);
      lookup("lk_req", 32'hC0A80101, 1'b1, 48'h001122334455);

      // Reply, then same reply aimed at another host
      send_frame(16'd2, 48'h0A0B0C0D0E0F, 32'hC0A80103, IP_LOCAL, 16'h0800, 28, 1'b0);
      check_pulses("rep", 1'b1, 1'b0, 1'b0);
      check("rep_tip", o_target_ip, 32'hC0A80103);
      send_frame(16'd2, 48'h0A0B0C0D0E99, 32'hC0A80103, 32'hC0A80109, 16'h0800, 28, 1'b0);
      check_pulses("rep_other", 1'b0, 1'b0, 1'b0);
      check("rep_other_tmac", o_target_mac, 48'h0A0B0C0D0E0F);
      lookup("lk_rep", 32'hC0A80103, 1'b1, 48'h0A0B0C0D0E0F);

      // Short frame, wrong PTYPE, then a gapped frame
      send_frame(16'd1, 48'h020000000007, 32'hC0A80107, IP_LOCAL, 16'h0800, 21, 1'b0);
      check_pulses("short", 1'b0, 1'b0, 1'b0);
      send_frame(16'd1, 48'h020000000008, 32'hC0A80108, IP_LOCAL, 16'h86DD, 28, 1'b0);
      check_pulses("ptype", 1'b0, 1'b0, 1'b0);
      lookup("lk_short", 32'hC0A80107, 1'b0, 48'h0);
      send_frame(16'd1, 48'h020000000004, 32'hC0A80104, IP_LOCAL, 16'h0800, 40, 1'b1);
      check_pulses("gaps", 1'b1, 1'b1, 1'b0);
      check("gaps_tip", o_target_ip, 32'hC0A80104);

      // Back-to-back lookups: hit then miss
      i_lookup_ip = 32'hC0A80104; i_lookup_valid = 1'b1;
      @(posedge i_clk); #1;
      check("b2b0_hit", o_lookup_hit, 1'b1);
      check("b2b0_mac", o_lookup_mac, 48'h020000000004);
      i_lookup_ip = 32'hC0A80163;
      @(posedge i_clk); #1;
      check("b2b1_done", o_lookup_done, 1'b1);
      check("b2b1_hit", o_lookup_hit, 1'b0);
      i_lookup_valid = 1'b0;
      @(posedge i_clk); #1;
      check("b2b_idle_done", o_lookup_done, 1'b0);

      // Reset in the middle of a frame with three entries learned
      for (int k = 0; k < 10; k++) begin
         i_mac_data = 8'h55; i_mac_valid = 1'b1; i_mac_last = 1'b0;
         @(posedge i_clk); #1;
      end
      i_mac_valid = 1'b0;
      i_rst = 1'b1;
      #2;
      check_pulses("midrst", 1'b0, 1'b0, 1'b0);
      check("midrst_tmac", o_target_mac, 48'h0);
      check("midrst_tip", o_target_ip, 32'h0);
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      lookup("lk_rst1", 32'hC0A80101, 1'b0, 48'h0);
      lookup("lk_rst3", 32'hC0A80103, 1'b0, 48'h0);
      lookup("lk_rst4", 32'hC0A80104, 1'b0, 48'h0);
      send_req(48'h020000000005, 32'hC0A80105, IP_LOCAL);
      check_pulses("postrst", 1'b1, 1'b1, 1'b0);
      check("postrst_tip", o_target_ip, 32'hC0A80105);
      lookup("lk_postrst", 32'hC0A80105, 1'b1, 48'h020000000005);

      // Replacement: fill four slots, evict, update in place
      pulse_reset();
      for (int i = 0; i < 5; i++) begin
         send_req(48'h0200000000A0 + 48'(i), 32'hC0A8010A + 32'(i), IP_LOCAL);
         check($sformatf("learn%0d_tv", i), o_target_valid, 1'b1);
      end
      lookup("lk_ev10", 32'hC0A8010A, 1'b0, 48'h0);
      lookup("lk_ev14", 32'hC0A8010E, 1'b1, 48'h0200000000A4);
      lookup("lk_ev11", 32'hC0A8010B, 1'b1, 48'h0200000000A1);
      send_req(48'h0300000000B1, 32'hC0A8010B, IP_LOCAL);
      check("relearn_tv", o_target_valid, 1'b1);
      lookup("lk_upd11", 32'hC0A8010B, 1'b1, 48'h0300000000B1);
      send_req(48'h0200000000A5, 32'hC0A8010F, IP_LOCAL);
      lookup("lk_ptr11", 32'hC0A8010B, 1'b0, 48'h0);
      lookup("lk_ptr12", 32'hC0A8010C, 1'b1, 48'h0200000000A2);
      lookup("lk_ptr15", 32'hC0A8010F, 1'b1, 48'h0200000000A5);

      // Runtime local IP change and IP conflict
      i_source_ip = 32'hC0A80132; i_s_ip_valid = 1'b1;
      @(posedge i_clk); #1;
      i_s_ip_valid = 1'b0;
      send_req(48'h020000000020, 32'hC0A80114, IP_LOCAL);
      check_pulses("oldip", 1'b0, 1'b0, 1'b0);
      send_req(48'h020000000020, 32'hC0A80114, 32'hC0A80132);
      check_pulses("newip", 1'b1, 1'b1, 1'b0);
      check("newip_tip", o_target_ip, 32'hC0A80114);
      send_req(48'h020000000032, 32'hC0A80132, 32'hC0A80132);
      check_pulses("conflict", 1'b0, 1'b0, 1'b1);
      check("conflict_tip", o_target_ip, 32'hC0A80114);
      @(posedge i_clk); #1;
      check("conflict_next", o_ip_conflict, 1'b0);
      lookup("lk_conflict", 32'hC0A80132, 1'b0, 48'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
